// File: rtl/alu_driver.sv
// alu_driver: valid/ready front end for the registered alu. It accepts one
// operation at a time, issues it with a single-cycle enable pulse, captures
// the result LAT cycles after the enable is sampled, and returns it on a
// valid/ready response port. It also keeps completion and overflow counters.
module alu_driver #(
    parameter int n   = 8,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [n-1:0] req_a,
    input  logic [n-1:0] req_b,
    input  logic [2:0]   req_op,
    output logic [n-1:0] alu_a,
    output logic [n-1:0] alu_b,
    output logic [2:0]   alu_op,
    output logic         alu_en,
    input  logic [n-1:0] alu_sum,
    input  logic         alu_o,
    input  logic         alu_z,
    input  logic         alu_n,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [n-1:0] rsp_sum,
    output logic [2:0]   rsp_flags,
    output logic [15:0]  op_count,
    output logic [7:0]   ovf_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Counter value loaded in ISSUE; the WAIT cycle in which it reads zero is
    // the one whose closing edge captures the result (edge T1+LAT).
    localparam logic [3:0] WAIT_LOAD = 4'(LAT - 1);

    state_t         state_reg;
    state_t         state_next;
    logic [3:0]     wait_cnt_reg;
    logic [n-1:0]   alu_a_reg;
    logic [n-1:0]   alu_b_reg;
    logic [2:0]     alu_op_reg;
    logic [n-1:0]   rsp_sum_reg;
    logic [2:0]     rsp_flags_reg;
    logic [15:0]    op_count_reg;
    logic [7:0]     ovf_count_reg;

    logic           accept;
    logic           capture;
    logic           handshake;

    assign accept    = (state_reg == IDLE) && req_valid;
    assign capture   = (state_reg == WAIT) && (wait_cnt_reg == 4'd0);
    assign handshake = (state_reg == RESP) && rsp_ready;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. With LAT=1 the single WAIT cycle is the capture cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (wait_cnt_reg == 4'd0) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake and enable outputs decode the state directly, so reset drops
    // alu_en immediately.
    always_comb begin
        req_ready = 1'b0;
        alu_en    = 1'b0;
        rsp_valid = 1'b0;
        case (state_reg)
            IDLE:    req_ready = 1'b1;
            ISSUE:   alu_en    = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Latency counter: loaded while issuing, counts down while waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_reg <= 4'd0;
        end else if (state_reg == ISSUE) begin
            wait_cnt_reg <= WAIT_LOAD;
        end else if (state_reg == WAIT && wait_cnt_reg != 4'd0) begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
        end
    end

    // Operand/opcode registers change only when a request is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_a_reg  <= '0;
            alu_b_reg  <= '0;
            alu_op_reg <= 3'd0;
        end else if (accept) begin
            alu_a_reg  <= req_a;
            alu_b_reg  <= req_b;
            alu_op_reg <= req_op;
        end
    end

    // Result capture; held stable through RESP until the handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_sum_reg   <= '0;
            rsp_flags_reg <= 3'd0;
        end else if (capture) begin
            rsp_sum_reg   <= alu_sum;
            rsp_flags_reg <= {alu_o, alu_z, alu_n};
        end
    end

    // Statistics: op_count wraps naturally, ovf_count saturates at 0xFF.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_count_reg  <= 16'd0;
            ovf_count_reg <= 8'd0;
        end else if (handshake) begin
            op_count_reg <= op_count_reg + 16'd1;
            if (rsp_flags_reg[2] && ovf_count_reg != 8'hFF) begin
                ovf_count_reg <= ovf_count_reg + 8'd1;
            end
        end
    end

    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign alu_op    = alu_op_reg;
    assign rsp_sum   = rsp_sum_reg;
    assign rsp_flags = rsp_flags_reg;
    assign op_count  = op_count_reg;
    assign ovf_count = ovf_count_reg;

endmodule
